// File: rtl/nfc_cmd_seq.sv
// nfc_cmd_seq: command sequencer in front of the NAND flash controller.
// Host requests are queued in a small FIFO. Each request is split into
// NFC commands so that no chunk crosses a flash page boundary and no chunk
// wraps the 128-byte internal memory. One command is released for each
// idle indication (done pulse) from the NFC.
//
// Command layout: {rw[32], flash_addr[31:14], mem_addr[13:7], len[6:0]}.
module nfc_cmd_seq #(
    parameter int DEPTH     = 4,
    parameter int PAGE_BITS = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_rw,
    input  logic [17:0]               req_faddr,
    input  logic [6:0]                req_maddr,
    input  logic [6:0]                req_len,
    output logic [32:0]               cmd,
    output logic                      cmd_vld,
    input  logic                      done,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    pend
);

    // Pointer and occupancy widths. DEPTH is a power of two, so the
    // pointers wrap naturally; the count needs one extra bit for "full".
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    // Room computations are done in 10 bits: enough for a 512-byte page
    // and for the 128-byte memory.
    localparam logic [9:0]    PAGE_SIZE = 10'(2 ** PAGE_BITS);
    localparam logic [9:0]    MEM_SIZE  = 10'd128;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    // Request FIFO storage: {rw, faddr, maddr, len}
    logic [32:0]           r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [32:0]           w_wr_data;
    logic [32:0]           w_rd_data;
    logic                  w_rd_rw;
    logic [17:0]           w_rd_fa;
    logic [6:0]            w_rd_ma;
    logic [6:0]            w_rd_len;

    // Working request being split
    logic                  r_rw;
    logic [17:0]           r_fa;
    logic [6:0]            r_ma;
    logic [6:0]            r_rem;
    logic [6:0]            r_chunk;

    // NFC handshake and command output
    logic                  r_nfc_idle;
    logic [32:0]           r_cmd;
    logic                  r_cmd_vld;
    logic                  w_issue;

    // Chunk size computation
    logic [9:0]            w_page_off;
    logic [9:0]            w_page_room;
    logic [9:0]            w_mem_room;
    logic [6:0]            w_chunk;
    logic [6:0]            w_rem_after;

    // ------------------------------------------------------------------
    // FIFO control. A full FIFO refuses a push even when a pop happens in
    // the same cycle, which keeps req_ready independent of the splitter.
    // ------------------------------------------------------------------
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign req_ready = !w_full && !rst;
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_wr_data = {req_rw, req_faddr, req_maddr, req_len};
    assign w_rd_data = r_mem[r_rd_ptr];
    assign {w_rd_rw, w_rd_fa, w_rd_ma, w_rd_len} = w_rd_data;

    // FIFO storage write; no reset so the array can map onto RAM
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // FIFO pointers and occupancy; reset flushes any queued requests
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Chunk = min(remaining, bytes left in flash page, bytes left before
    // the memory wraps). Since remaining <= 127 the result fits 7 bits,
    // and each room term is at least 1, so the chunk is never zero while
    // remaining is non-zero.
    // ------------------------------------------------------------------
    // Combinational chunk size from the working registers
    always_comb begin
        w_page_off  = 10'(r_fa[PAGE_BITS-1:0]);
        w_page_room = PAGE_SIZE - w_page_off;
        w_mem_room  = MEM_SIZE - {3'b000, r_ma};
        w_chunk     = r_rem;
        if (w_page_room < {3'b000, w_chunk}) begin
            w_chunk = w_page_room[6:0];
        end
        if (w_mem_room < {3'b000, w_chunk}) begin
            w_chunk = w_mem_room[6:0];
        end
    end

    assign w_rem_after = r_rem - r_chunk;

    // ------------------------------------------------------------------
    // Splitter FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and issue decision
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Zero-length requests are popped and dropped here
                if (!w_empty) begin
                    w_state_next = (w_rd_len == '0) ? S_IDLE : S_CALC;
                end
            end
            S_CALC: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_nfc_idle) begin
                    w_issue      = 1'b1;
                    w_state_next = (w_rem_after != '0) ? S_CALC : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Working registers, chunk register and command output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rw      <= 1'b0;
            r_fa      <= '0;
            r_ma      <= '0;
            r_rem     <= '0;
            r_chunk   <= '0;
            r_cmd     <= '0;
            r_cmd_vld <= 1'b0;
        end else begin
            r_cmd_vld <= w_issue;
            if (w_pop) begin
                r_rw  <= w_rd_rw;
                r_fa  <= w_rd_fa;
                r_ma  <= w_rd_ma;
                r_rem <= w_rd_len;
            end
            if (r_state == S_CALC) begin
                r_chunk <= w_chunk;
            end
            if (w_issue) begin
                r_cmd <= {r_rw, r_fa, r_ma, r_chunk};
                // Flash address wraps mod 2^18, memory address mod 128
                r_fa  <= r_fa + 18'(r_chunk);
                r_ma  <= r_ma + r_chunk;
                r_rem <= w_rem_after;
            end
        end
    end

    // NFC idle flag: a done is remembered until the next issue; an issue
    // in the same cycle as a done clears the flag and that done is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nfc_idle <= 1'b0;
        end else if (w_issue) begin
            r_nfc_idle <= 1'b0;
        end else if (done) begin
            r_nfc_idle <= 1'b1;
        end
    end

    assign cmd     = r_cmd;
    assign cmd_vld = r_cmd_vld;
    assign pend    = r_count;
    assign busy    = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_nfc_cmd_seq.sv
// Testbench for nfc_cmd_seq: expected commands are derived from each
// accepted request by a chunking model and queued; a monitor compares
// every cmd_vld strobe against the queue head.
module tb_nfc_cmd_seq;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [17:0] req_faddr = '0;
    logic [6:0]  req_maddr = '0;
    logic [6:0]  req_len = '0;
    logic [32:0] cmd;
    logic        cmd_vld;
    logic        done = 1'b0;
    logic        busy;
    logic [2:0]  pend;

    int          checks = 0;
    int          errors = 0;
    int          vld_cnt = 0;
    logic [32:0] exp_q[$];
    logic [32:0] last_exp = '0;
    logic        prev_vld = 1'b0;

    nfc_cmd_seq #(.DEPTH(DEPTH), .PAGE_BITS(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_faddr (req_faddr),
        .req_maddr (req_maddr),
        .req_len   (req_len),
        .cmd       (cmd),
        .cmd_vld   (cmd_vld),
        .done      (done),
        .busy      (busy),
        .pend      (pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the request in chunks limited by remaining length,
    // room left in the 512-byte flash page and room left in 128-byte memory.
    task automatic model_push(input logic rw, input logic [17:0] fa_in,
                              input logic [6:0] ma_in, input logic [6:0] len_in);
        int f = int'(fa_in);
        int m = int'(ma_in);
        int r = int'(len_in);
        int c;
        while (r > 0) begin
            c = r;
            if (512 - (f % 512) < c) c = 512 - (f % 512);
            if (128 - m < c) c = 128 - m;
            exp_q.push_back({rw, 18'(f), 7'(m), 7'(c)});
            f = (f + c) % 262144;
            m = (m + c) % 128;
            r = r - c;
        end
    endtask

    // Monitor: one line per issued command, checked against the queue
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            last_exp = '0;
            prev_vld = 1'b0;
        end else begin
            if (cmd_vld) begin
                vld_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got %h with no command expected", cmd);
                end else begin
                    e = exp_q.pop_front();
                    $display("cmd rw=%0d fa=%05h ma=%02h len=%0d (expected %h)",
                             cmd[32], cmd[31:14], cmd[13:7], cmd[6:0], e);
                    check("cmd", 64'(cmd), 64'(e));
                    last_exp = e;
                end
                check("vld_single_cycle", 64'(prev_vld), 64'(0));
            end else begin
                check("cmd_hold", 64'(cmd), 64'(last_exp));
            end
            prev_vld = cmd_vld;
        end
    end

    // All driver tasks start and end at posedge+1
    task automatic push_req(input logic rw, input logic [17:0] fa,
                            input logic [6:0] ma, input logic [6:0] len);
        int n = 0;
        bit acc = 1'b0;
        req_valid = 1'b1;
        req_rw    = rw;
        req_faddr = fa;
        req_maddr = ma;
        req_len   = len;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            n++;
        end
        check("push_accepted", 64'(acc), 64'(1));
        if (acc) model_push(rw, fa, ma, len);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 pulse_done();
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
        check("drain_busy", 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("ready_in_reset", 64'(req_ready), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd", 64'(cmd), 64'(0));
        check("rst_vld", 64'(cmd_vld), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_pend", 64'(pend), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v0;
        int accepts;
        bit acc;
        bit pushes_done;
        int guard;

        do_reset();

        // Simple read with no idle indication yet: waits for done
        push_req(1'b1, 18'h00100, 7'h00, 7'd64);
        v0 = vld_cnt;
        repeat (5) @(posedge clk);
        #1 check("no_issue_without_done", 64'(vld_cnt), 64'(v0));
        done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
        @(negedge clk);
        check("vld_before_issue", 64'(cmd_vld), 64'(0));
        @(negedge clk);
        check("vld_after_done", 64'(cmd_vld), 64'(1));
        @(negedge clk);
        check("vld_drops", 64'(cmd_vld), 64'(0));
        check("busy_after_read", 64'(busy), 64'(0));
        @(posedge clk);
        #1;

        // Page crossing with idle remembered: 3-cycle latency from push
        pulse_done();
        push_req(1'b0, 18'h001F0, 7'h00, 7'd64);
        v0 = vld_cnt;
        repeat (3) begin
            @(negedge clk);
            check("latency_early", 64'(cmd_vld), 64'(0));
        end
        @(negedge clk);
        check("latency_3", 64'(cmd_vld), 64'(1));
        repeat (6) @(negedge clk);
        check("second_chunk_waits", 64'(vld_cnt), 64'(v0 + 1));
        @(posedge clk);
        #1 drain();

        // Memory wrap; a done coinciding with the issue is ignored
        pulse_done();
        push_req(1'b1, 18'h00000, 7'h70, 7'd48);
        v0 = vld_cnt;
        @(posedge clk);
        @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
        repeat (8) @(posedge clk);
        #1 check("coincident_done_ignored", 64'(vld_cnt), 64'(v0 + 1));
        drain();
        check("wrap_two_chunks", 64'(vld_cnt), 64'(v0 + 2));

        // Both limits, and a flash address wrapping past 0x3FFFF
        push_req(1'b0, 18'h003F8, 7'h7C, 7'd20);
        push_req(1'b1, 18'h3FFF0, 7'h05, 7'd40);
        drain();

        // Backpressure with done held low; third accepted request is empty
        do_reset();
        accepts = 0;
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_faddr = 18'($urandom);
        req_maddr = 7'($urandom);
        req_len   = 7'($urandom_range(1, 127));
        repeat (12) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            if (acc) begin
                model_push(req_rw, req_faddr, req_maddr, req_len);
                accepts++;
                #1;
                req_rw    = 1'($urandom);
                req_faddr = 18'($urandom);
                req_maddr = 7'($urandom);
                req_len   = (accepts == 2) ? 7'd0 : 7'($urandom_range(1, 127));
            end else begin
                #1;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_accepts", 64'(accepts), 64'(DEPTH + 1));
        check("bp_ready", 64'(req_ready), 64'(0));
        check("bp_pend", 64'(pend), 64'(DEPTH));
        @(posedge clk);
        #1 drain();

        // Reset between chunks of a page-crossing request
        pulse_done();
        push_req(1'b0, 18'h001F0, 7'h00, 7'd64);
        v0 = vld_cnt;
        guard = 0;
        while (vld_cnt == v0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        check("first_chunk_seen", 64'(vld_cnt), 64'(v0 + 1));
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_cmd", 64'(cmd), 64'(0));
        check("midrst_pend", 64'(pend), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        v0 = vld_cnt;
        @(posedge clk);
        #1 pulse_done();
        repeat (6) @(posedge clk);
        #1 check("midrst_no_cmd", 64'(vld_cnt), 64'(v0));

        // Random traffic with random done pulses
        pushes_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [17:0] fa;
                    fa = ($urandom_range(0, 3) == 0) ? 18'(18'h3FFFF - 18'($urandom_range(0, 63)))
                                                    : 18'($urandom);
                    push_req(1'($urandom), fa, 7'($urandom),
                             ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom));
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    #1;
                end
                pushes_done = 1'b1;
            end
            begin
                int n = 0;
                while (!(pushes_done && exp_q.size() == 0) && n < 20000) begin
                    @(posedge clk);
                    #1 done = ($urandom_range(0, 2) == 0);
                    n++;
                end
                done = 1'b0;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        check("final_busy", 64'(busy), 64'(0));
        check("final_pend", 64'(pend), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
